// File: rtl/levinson_order_update.sv
// levinson_order_update: one Levinson-Durbin order-update step over an on-chip Q(FRAC_W) coefficient file
// Ports: iStart/iM/iKm request order m with reflection km; iLoad* preload a[1..MAX_ORDER] while idle;
//        iRdIdx/oRdData registered read port; oBusy during update, oDone/oErr completion pulse, oSat sticky clamp flag
module levinson_order_update #(
    parameter int DATA_W    = 32,
    parameter int FRAC_W    = 30,
    parameter int MAX_ORDER = 12,
    parameter int ORDER_W   = 4
) (
    input  logic                      iClock,
    input  logic                      iReset,
    input  logic                      iStart,
    input  logic [ORDER_W-1:0]        iM,
    input  logic signed [DATA_W-1:0]  iKm,
    input  logic                      iLoadEn,
    input  logic [ORDER_W-1:0]        iLoadIdx,
    input  logic [DATA_W-1:0]         iLoadData,
    input  logic [ORDER_W-1:0]        iRdIdx,
    output logic [DATA_W-1:0]         oRdData,
    output logic                      oBusy,
    output logic                      oDone,
    output logic                      oErr,
    output logic                      oSat
);
    typedef enum logic [1:0] {IDLE, CALC, COMMIT, REJECT} state_t;
    localparam logic [ORDER_W-1:0] MAX_IDX = ORDER_W'(MAX_ORDER);
    localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_W;
    localparam logic signed [2*DATA_W-1:0] SMAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W-1:0] SMIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    state_t state, state_nx;
    logic signed [DATA_W-1:0] a [0:MAX_ORDER];
    logic signed [DATA_W-1:0] km_r, a_lo, a_hi, s_lo, s_hi;
    logic signed [2*DATA_W-1:0] p_lo, p_hi, w_lo, w_hi;
    logic [ORDER_W-1:0] m_r, j, lo, hi;
    logic c_lo, c_hi, ok;
    // Pair (j, m-j) is updated from both old values in one cycle; the sum is kept
    // wide so any overflow of the DATA_W range is caught by the clamp.
    always_comb begin
        lo   = j;
        hi   = m_r - j;
        a_lo = (lo <= MAX_IDX) ? a[lo] : '0;
        a_hi = (hi <= MAX_IDX) ? a[hi] : '0;
        p_lo = (2*DATA_W)'(km_r) * (2*DATA_W)'(a_hi);
        p_hi = (2*DATA_W)'(km_r) * (2*DATA_W)'(a_lo);
        w_lo = (2*DATA_W)'(a_lo) + (p_lo >>> FRAC_W);
        w_hi = (2*DATA_W)'(a_hi) + (p_hi >>> FRAC_W);
        c_lo = (w_lo > SMAX) || (w_lo < SMIN);
        c_hi = (w_hi > SMAX) || (w_hi < SMIN);
        s_lo = (w_lo > SMAX) ? DATA_W'(SMAX) : (w_lo < SMIN) ? DATA_W'(SMIN) : w_lo[DATA_W-1:0];
        s_hi = (w_hi > SMAX) ? DATA_W'(SMAX) : (w_hi < SMIN) ? DATA_W'(SMIN) : w_hi[DATA_W-1:0];
        ok   = (iM != '0) && (iM <= MAX_IDX);
    end
    always_ff @(posedge iClock or negedge iReset)
        if (!iReset) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (iStart) state_nx = !ok ? REJECT : (iM[ORDER_W-1:1] != '0) ? CALC : COMMIT;
            CALC:   if (j == (m_r >> 1)) state_nx = COMMIT;
            COMMIT: state_nx = IDLE;
            REJECT: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            for (int i = 0; i <= MAX_ORDER; i++) a[i] <= (i == 0) ? ONE : '0;
            km_r    <= '0;
            m_r     <= '0;
            j       <= '0;
            oRdData <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oErr    <= 1'b0;
            oSat    <= 1'b0;
        end else begin
            oRdData <= (iRdIdx <= MAX_IDX) ? a[iRdIdx] : '0;
            oDone   <= (state == COMMIT) || (state == REJECT);
            oErr    <= (state == REJECT);
            case (state)
                IDLE:
                    if (iStart && ok) begin
                        m_r   <= iM;
                        km_r  <= iKm;
                        j     <= ORDER_W'(1);
                        oSat  <= 1'b0;
                        oBusy <= 1'b1;
                    end else if (iLoadEn && !iStart && iLoadIdx != '0 && iLoadIdx <= MAX_IDX)
                        a[iLoadIdx] <= iLoadData;
                CALC: begin
                    a[lo] <= s_lo;
                    if (lo != hi) a[hi] <= s_hi;
                    oSat <= oSat || c_lo || ((lo != hi) && c_hi);
                    j    <= j + 1'b1;
                end
                COMMIT: begin
                    a[m_r] <= km_r;
                    oBusy  <= 1'b0;
                end
                REJECT: ;
            endcase
        end
    end
endmodule

// File: doc/levinson_order_update.md
Name: levinson_order_update

Overview:
- Performs one Levinson-Durbin order-update step over an internal predictor-coefficient register file.
- For order m with reflection coefficient km, computes a[i] <= a[i] + km*a[m-i] for i = 1..m-1, then a[m] <= km.
- Processes symmetric index pairs (i, m-i) in one cycle and keeps all coefficients on-chip, so the LPC solver only supplies km and m per order.
- Parametrised fixed-point successor to the float pair-selector; adds saturation, error reporting and a read port.

Parameters:
DATA_W, 32, coefficient and km width (signed two's complement)
FRAC_W, 30, fractional bits (default Q2.30; 1.0 = 0x40000000)
MAX_ORDER, 12, highest supported order; storage is a[0..MAX_ORDER]
ORDER_W, 4, width of order/index ports (must hold MAX_ORDER)

Ports:
iClock  in  1  clock, rising edge
iReset  in  1  asynchronous, active-low reset
iStart  in  1  request one order update (sampled only in IDLE)
iM  in  ORDER_W  target order m
iKm  in  DATA_W  reflection coefficient km, signed
iLoadEn  in  1  write iLoadData into a[iLoadIdx] (IDLE only)
iLoadIdx  in  ORDER_W  load index
iLoadData  in  DATA_W  load value
iRdIdx  in  ORDER_W  read index
oRdData  out  DATA_W  registered a[iRdIdx]
oBusy  out  1  update in progress
oDone  out  1  one-cycle completion pulse
oErr  out  1  pulses with oDone when request was rejected
oSat  out  1  sticky: saturation occurred in current/last update

Behaviour:
- Reset (iReset low, asynchronous): a[0]=1<<FRAC_W, a[1..MAX_ORDER]=0; state IDLE; oRdData, oBusy, oDone, oErr, oSat = 0. Reset mid-update aborts it and restores these values.
- a[0] is constant 1.0; loads to index 0 and indices above MAX_ORDER are ignored.
- States: IDLE, CALC, COMMIT, REJECT.
- IDLE, iStart=1, 1<=iM<=MAX_ORDER (sampled at edge 0):
  - Latches m and km, clears oSat, sets oBusy, j=1.
  - Next state is CALC if P=floor(m/2)>0, else COMMIT.
- IDLE, iStart=1, iM=0 or iM>MAX_ORDER: go to REJECT. Next edge: oDone=oErr=1 for one cycle; no coefficient change; back to IDLE.
- CALC, edges 1..P (pair j):
  - lo=j, hi=m-j. Both old values are read in the same cycle.
  - lo<hi: a[lo] <= sat(a[lo] + (km*a[hi] >>> FRAC_W)) and a[hi] <= sat(a[hi] + (km*a[lo] >>> FRAC_W)).
  - lo==hi (m even, j=m/2): single write a[lo] <= sat(a[lo] + (km*a[lo] >>> FRAC_W)).
  - j increments; after j=P go to COMMIT.
- COMMIT, edge P+1: a[m] <= km; oDone=1, oBusy=0; state IDLE. oDone clears at edge P+2.
- Total: start at edge 0, oDone high for the cycle following edge P+1; oBusy high from edge 0 through edge P+1.
- Arithmetic:
  - Product is full 2*DATA_W signed; arithmetic shift right by FRAC_W truncates toward -inf.
  - Sum is computed in DATA_W+1 bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Any clamp sets oSat (sticky until next accepted start or reset).
- iStart while oBusy: ignored, no queueing.
- iLoadEn while busy: ignored. iLoadEn with iStart in the same IDLE cycle: start wins, load dropped.
- Read port: oRdData <= a[iRdIdx] every edge, including mid-update (shows partially updated values); iRdIdx>MAX_ORDER returns 0.
- Back-to-back: a new iStart is accepted in the cycle oDone is high.

Test Plan:
- Reset check: after reset, reads of idx 0..12 -> 0x40000000, then 0 x12; oBusy=oDone=oErr=oSat=0.
- m=1: iKm=0xE0000000 (-0.5) -> oDone after edge 1 (P=0); a[1]=0xE0000000, a[2..]=0.
- m=2: a[1]=0xE0000000 loaded; iKm=0x20000000 (0.5) -> a[1]=0xD0000000 (-0.75), a[2]=0x20000000; oDone after edge 2.
- m=3: from the m=2 result, iKm=0x10000000 (0.25) -> a[1]=0xD8000000 (-0.625), a[2]=0x14000000 (0.3125), a[3]=0x10000000; oDone after edge 2.
- Saturation: load a[1]=0x70000000 (1.75), m=2, iKm=0x40000000 -> a[1]=0x7FFFFFFF, a[2]=0x40000000, oSat=1; next accepted start clears oSat.
- Errors and aborts:
  - iM=0 -> oDone=oErr=1 for one cycle, coefficients unchanged.
  - iStart while busy -> ignored.
  - m=12 with iReset pulled low mid-CALC -> all coefficients return to reset values, oBusy=0.
